// File: rtl/idex_stage_buffer_if.sv
// idex_stage_buffer_if: ID->EX beat bus (ID side handshake, EX side handshake, flush)
interface idex_stage_buffer_if #(
    parameter int CTRL_W  = 12,
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 3,
    parameter int RD_W    = 4,
    parameter int AMT_W   = 12
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [NUM_OPS*DATA_W-1:0] in_ops;
    logic [AMT_W-1:0]          in_amt;
    logic [RD_W-1:0]           in_rd;
    logic                      out_valid;
    logic                      out_ready;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [NUM_OPS*DATA_W-1:0] out_ops;
    logic [AMT_W-1:0]          out_amt;
    logic [RD_W-1:0]           out_rd;
    logic [2:0]                out_stype;
    modport master (
        output flush, in_valid, in_ctrl, in_ops, in_amt, in_rd, out_ready,
        input  in_ready, out_valid, out_ctrl, out_ops, out_amt, out_rd, out_stype
    );
    modport slave (
        input  flush, in_valid, in_ctrl, in_ops, in_amt, in_rd, out_ready,
        output in_ready, out_valid, out_ctrl, out_ops, out_amt, out_rd, out_stype
    );
endinterface

// File: rtl/idex_stage_buffer.sv
// idex_stage_buffer: ID/EX stage with 2-entry skid buffer, registered in_ready and flush bubble.
// Define IDEX_STAGE_STATS_EN to add saturating stall/flush/bubble counters.
module idex_stage_buffer #(
    parameter int CTRL_W    = 12,
    parameter int DATA_W    = 32,
    parameter int NUM_OPS   = 3,
    parameter int RD_W      = 4,
    parameter int AMT_W     = 12,
    parameter int STYPE_CH  = 1,
    parameter int STYPE_LSB = 25
) (
    input  logic                    CLK,
    input  logic                    CLR,
    idex_stage_buffer_if.slave      bus
`ifdef IDEX_STAGE_STATS_EN
    ,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             flush_cnt,
    output logic [15:0]             bubble_cnt
`endif
);
    localparam int PW = CTRL_W + NUM_OPS*DATA_W + AMT_W + RD_W + 3;

    if (STYPE_LSB + 2 >= DATA_W || STYPE_CH >= NUM_OPS) begin : g_bad_stype
        $error("idex_stage_buffer: shifter-type field lies outside the operand channels");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          st, st_n;
    logic [PW-1:0]   m_q, s_q, m_n, s_n, in_pay;
    logic            rdy_q, acc, pop, ov;

    // stype is frozen into the entry at acceptance, never recomputed at the output
    assign in_pay = {bus.in_ctrl, bus.in_ops, bus.in_amt, bus.in_rd,
                     bus.in_ops[STYPE_CH*DATA_W+STYPE_LSB +: 3]};
    assign ov     = st != EMPTY;
    assign acc    = bus.in_valid & rdy_q;
    assign pop    = ov & bus.out_ready;

    always_comb begin
        st_n = st;
        m_n  = m_q;
        s_n  = s_q;
        if (bus.flush) begin
            st_n = EMPTY;
            m_n  = '0;
            s_n  = '0;
        end else begin
            case (st)
                EMPTY: if (acc) begin
                    st_n = ONE;
                    m_n  = in_pay;
                end
                ONE: if (acc && pop) begin
                    m_n  = in_pay;
                end else if (acc) begin
                    st_n = TWO;
                    s_n  = in_pay;
                end else if (pop) begin
                    st_n = EMPTY;
                end
                TWO: if (pop) begin
                    st_n = ONE;
                    m_n  = s_q;
                end
                default: st_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            st    <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
            rdy_q <= 1'b1;
        end else begin
            st    <= st_n;
            m_q   <= m_n;
            s_q   <= s_n;
            rdy_q <= st_n != TWO;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = ov;
    assign {bus.out_ctrl, bus.out_ops, bus.out_amt, bus.out_rd, bus.out_stype} = m_q;

`ifdef IDEX_STAGE_STATS_EN
    always_ff @(posedge CLK) begin
        if (CLR) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (ov && !bus.out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
            if (bus.flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 16'd1;
            if (!ov && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_idex_stage_buffer.sv
// tb_idex_stage_buffer: directed + random stimulus against a queue-based reference of the stage.
module tb_idex_stage_buffer;
    localparam int CTRL_W = 12, DATA_W = 32, NUM_OPS = 3, RD_W = 4, AMT_W = 12;
    localparam int STYPE_CH = 1, STYPE_LSB = 25;
    localparam int OW = NUM_OPS*DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [OW-1:0]     ops;
        logic [AMT_W-1:0]  amt;
        logic [RD_W-1:0]   rd;
    } beat_t;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    idex_stage_buffer_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .RD_W(RD_W), .AMT_W(AMT_W)) bus ();

    idex_stage_buffer #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .RD_W(RD_W), .AMT_W(AMT_W),
        .STYPE_CH(STYPE_CH), .STYPE_LSB(STYPE_LSB)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .bus(bus)
    );

    beat_t q[$];
    beat_t held, h;
    int    checks = 0, passed = 0, fails = 0;
    bit    chk = 0;
    bit    a;

    function automatic logic [2:0] stype_of(beat_t b);
        return 3'((b.ops >> (STYPE_CH*DATA_W + STYPE_LSB)) & 96'd7);
    endfunction

    function automatic beat_t mk(int rd, logic [31:0] ch1);
        beat_t b;
        b.ctrl = CTRL_W'($urandom);
        b.ops  = {$urandom, ch1, $urandom};
        b.amt  = AMT_W'($urandom);
        b.rd   = RD_W'(rd);
        return b;
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive, compare outputs against the model, then advance the model
    task automatic tick(input bit v, input beat_t b, input bit ordy, input bit fl, input bit clr, output bit acc);
        bit pop;
        bus.in_valid  = v;
        bus.in_ctrl   = b.ctrl;
        bus.in_ops    = b.ops;
        bus.in_amt    = b.amt;
        bus.in_rd     = b.rd;
        bus.out_ready = ordy;
        bus.flush     = fl;
        CLR           = clr;
        #1;
        if (chk) begin
            h = q.size() > 0 ? q[0] : held;
            check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
            check("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
            check("out_ctrl", 128'(bus.out_ctrl), 128'(h.ctrl));
            check("out_ops", 128'(bus.out_ops), 128'(h.ops));
            check("out_amt", 128'(bus.out_amt), 128'(h.amt));
            check("out_rd", 128'(bus.out_rd), 128'(h.rd));
            check("out_stype", 128'(bus.out_stype), 128'(stype_of(h)));
        end
        @(posedge CLK);
        acc = v && q.size() < 2;
        pop = q.size() > 0 && ordy;
        if (clr || fl) begin
            q.delete();
            held = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
            if (q.size() > 0) held = q[0];
        end
        @(negedge CLK);
    endtask

    task automatic offer(beat_t b, bit ordy);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) tick(1, b, ordy, 0, 0, ok);
        check("offer_accepted", 128'(ok), 128'(1));
    endtask

    task automatic idle(int n, bit ordy);
        bit x;
        for (int i = 0; i < n; i++) tick(0, '0, ordy, 0, 0, x);
    endtask

    initial begin
        held = '0;
        tick(1, mk(2, 32'h1234_5678), 0, 0, 1, a);
        chk = 1;
        tick(1, mk(3, 32'h1234_5678), 0, 0, 1, a);
        idle(1, 0);
        for (int r = 1; r <= 5; r++) offer(mk(r, 32'h0E00_0000), 1);
        idle(2, 1);
        offer(mk(7, 32'h0200_0000), 0);
        offer(mk(8, 32'h0400_0000), 0);
        h = mk(9, 32'h0600_0000);
        for (int i = 0; i < 3; i++) tick(1, h, 0, 0, 0, a);
        offer(h, 1);
        idle(3, 1);
        offer(mk(3, $urandom), 0);
        offer(mk(4, $urandom), 0);
        tick(1, mk(5, $urandom), 0, 1, 0, a);
        idle(3, 1);
        offer(mk(6, $urandom), 0);
        tick(1, mk(7, $urandom), 0, 1, 1, a);
        idle(2, 0);
        for (int i = 0; i < 400; i++) begin
            tick($urandom % 4 != 0, mk(int'($urandom % 16), $urandom), $urandom % 3 != 0,
                 $urandom % 20 == 0, $urandom % 50 == 0, a);
        end
        idle(3, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/idex_stage_buffer.md
Name: idex_stage_buffer

Overview:
- Parametrised ID/EX pipeline stage with a valid/ready handshake, a 2-entry skid buffer, and a flush that inserts a bubble.
- Replaces fixed-width ID/EX latching. Generalised to N operand channels and arbitrary control-bundle width.
- Lets EX stall without a combinational ready path back into ID.
- Extracts the shifter-type field from a selectable operand channel as the data enters the stage.

Parameters:
- CTRL_W, 12, width of the packed control bundle (shift, ALU op, size, enable, rw, load, rf, and so on).
- DATA_W, 32, width of each operand channel.
- NUM_OPS, 3, number of operand channels (A, B, C, ...).
- RD_W, 4, destination-register field width.
- AMT_W, 12, shifter-amount field width.
- STYPE_CH, 1, operand channel index the shifter type is taken from.
- STYPE_LSB, 25, LSB of the 3-bit shifter-type field within channel STYPE_CH.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries and the incoming beat.
- in_valid  in  1  ID presents a beat.
- in_ready  out  1  stage accepts a beat; driven directly from a register.
- in_ctrl  in  CTRL_W  control bundle.
- in_ops  in  NUM_OPS*DATA_W  operands, channel k at bits [k*DATA_W +: DATA_W].
- in_amt  in  AMT_W  shifter amount.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  EX beat valid.
- out_ready  in  1  EX accepts the beat.
- out_ctrl, out_ops, out_amt, out_rd  out  same widths as the inputs  head-entry payload.
- out_stype  out  3  shifter type, captured from in_ops channel STYPE_CH bits [STYPE_LSB+2:STYPE_LSB] at acceptance.

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S. Each entry holds {ctrl, ops, amt, rd, stype} plus a valid bit.
- States are derived from the valid bits: EMPTY (neither valid), ONE (only M valid), TWO (M and S valid).
- Handshakes:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = !S.valid, registered; it is 0 only in TWO.
  - out_valid = M.valid.
- Transitions when flush=0:
  - EMPTY + accept -> ONE; M <= input.
  - ONE + accept + pop -> ONE; M <= input.
  - ONE + accept, no pop -> TWO; S <= input.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; M <= S. No accept is possible in TWO.
  - Anything else: hold. All payload bits are frozen while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; no beat is ever duplicated or dropped, except by flush.
- Latency: a beat accepted in cycle t appears at the outputs in cycle t+1 when the stage was EMPTY, or when it was ONE and popped in cycle t.
- stype is captured at acceptance, not recomputed at the output.
- Flush (synchronous):
  - Next cycle: M.valid=0, S.valid=0, in_ready=1.
  - Any beat accepted in the flush cycle is discarded.
  - Payload registers are zeroed, so EX sees an all-zero bubble.
  - A pop in the flush cycle still completes; EX consumes the current head.
- CLR:
  - Highest priority, above flush.
  - Next cycle: all valids 0, all payload outputs 0, out_stype=0, in_ready=1.
  - CLR asserted mid-stall (state TWO) discards both entries.
- Simultaneous flush and in_valid: the beat is dropped, and in_ready that cycle still reads its registered value.
- Widths: no arithmetic on the datapath. Requirement: STYPE_LSB+2 < DATA_W and STYPE_CH < NUM_OPS; violating either is an elaboration-time error.

Optional Feature:
- Macro: IDEX_STAGE_STATS_EN.
- When defined, three 16-bit outputs are added:
  - stall_cnt: increments each cycle with out_valid=1 and out_ready=0.
  - flush_cnt: increments each cycle flush=1.
  - bubble_cnt: increments each cycle out_valid=0 and CLR=0.
- All three saturate at 16'hFFFF and are zeroed by CLR.
- When undefined, these ports and their logic do not exist and the stage behaviour is otherwise identical.

Test Plan:
- CLR held for 2 cycles with in_valid=1 -> out_valid=0, out_ops=0, out_stype=0, in_ready=1 after release.
- Streaming, out_ready=1, beats with rd=1..5 and channel1=32'h0E00_0000 -> outputs rd 1..5 on consecutive cycles at 1-cycle latency, out_stype=3'b111.
- Beats rd=7, 8, 9 with out_ready=0 -> in_ready drops after rd=8 is accepted and rd=9 is held off. Raise out_ready -> outputs 7, 8, 9 in order, and payload stays stable while stalled.
- State TWO (rd=3 in M, rd=4 in S) plus flush, with rd=5 offered -> next cycle out_valid=0, all payload 0, in_ready=1, and rd=5 is never observed.
- Flush and CLR asserted together in state ONE -> reset values. With IDEX_STAGE_STATS_EN defined, flush_cnt=0.
- With IDEX_STAGE_STATS_EN defined: 10 stall cycles plus 2 flushes -> stall_cnt=10, flush_cnt=2. Force stall_cnt to 16'hFFFF and stall again -> it holds 16'hFFFF.
